// File: rtl/dmem_pkg.sv
// Shared types and width constants for the data-memory responder.
package dmem_pkg;
    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = 2;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: byte enables, store shift, load extract/extend.
// DMEM_MISALIGN_TRAP_EN: misaligned half/word raises err instead of forcing alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic              we_i,
    input  logic [OFFW-1:0]   off_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   mem_word_i,
    output logic [NBYTES-1:0] be_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              err_o
);
    logic            illegal, half, word, uns;
    logic [OFFW-1:0] off;
    logic [XLEN-1:0] lane;

    always_comb begin
        illegal = 1'b0;
        half    = 1'b0;
        word    = 1'b0;
        case (funct3_i)
            LSU_B:  begin end
            LSU_H:  half = 1'b1;
            LSU_W:  word = 1'b1;
            LSU_BU: illegal = we_i;
            LSU_HU: begin half = 1'b1; illegal = we_i; end
            default: illegal = 1'b1;
        endcase
    end

    assign uns = funct3_i[2];
    // Without trapping, the low offset bits are simply dropped to the access size.
    assign off = word ? '0 : (half ? {off_i[1], 1'b0} : off_i);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err_o = illegal | (half & off_i[0]) | (word & (|off_i));
`else
    assign err_o = illegal;
`endif

    assign wdata_o = wdata_i << {off, 3'b000};
    assign lane    = mem_word_i >> {off, 3'b000};

    always_comb begin
        if (word)      be_o = 4'b1111;
        else if (half) be_o = 4'b0011 << off;
        else           be_o = 4'b0001 << off;
        if (!we_i || err_o) be_o = '0;
    end

    always_comb begin
        if (word)      rdata_o = lane;
        else if (half) rdata_o = {{16{~uns & lane[15]}}, lane[15:0]};
        else           rdata_o = {{24{~uns & lane[7]}}, lane[7:0]};
        if (we_i || err_o) rdata_o = '0;
    end
endmodule

// File: rtl/data_mem_responder.sv
// Load/store target for the RV32IM core: one request at a time, fixed wait, single response.
// Optional DMEM_MISALIGN_TRAP_EN (see dmem_lane_align) turns misaligned half/word into errors.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int WORDS     = 1 << (ADDR_WIDTH - OFFW);
    localparam int CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    dmem_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [2:0]            f3_q;
    logic                  err_q;
    logic                  take, do_acc;

    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [2:0]            acc_f3;
    logic [NBYTES-1:0]     be;
    logic [XLEN-1:0]       st_data, ld_data, mem_word;
    logic                  acc_err;

    logic [XLEN-1:0] mem_q [WORDS];

    // With no wait the access happens on the accept edge, so use the live request.
    assign acc_we    = ZERO_WAIT ? req_we     : we_q;
    assign acc_addr  = ZERO_WAIT ? req_addr   : addr_q;
    assign acc_wdata = ZERO_WAIT ? req_wdata  : wdata_q;
    assign acc_f3    = ZERO_WAIT ? req_funct3 : f3_q;
    assign mem_word  = mem_q[acc_addr[ADDR_WIDTH-1:OFFW]];

    dmem_lane_align u_align (
        .funct3_i   (acc_f3),
        .we_i       (acc_we),
        .off_i      (acc_addr[OFFW-1:0]),
        .wdata_i    (acc_wdata),
        .mem_word_i (mem_word),
        .be_o       (be),
        .wdata_o    (st_data),
        .rdata_o    (ld_data),
        .err_o      (acc_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        do_acc  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                take = 1'b1;
                if (ZERO_WAIT) begin
                    do_acc  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    do_acc  = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (do_acc) begin
                rdata_q <= ld_data;
                err_q   <= acc_err;
            end
        end
    end

    // Array is not reset; a reset on the commit edge discards the store.
    always_ff @(posedge clk) begin
        if (do_acc && !rst) begin
            for (int b = 0; b < NBYTES; b++)
                if (be[b]) mem_q[acc_addr[ADDR_WIDTH-1:OFFW]][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Table-driven scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and a zero-wait instance).
module tb_data_mem_responder;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int WC = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] WORD100 = TRAP ? 32'hDEAD7FEF : 32'hDEAD1234;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, resp_rdata;
    logic [2:0]    req_funct3;

    logic          req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, resp_err0;
    logic [AW-1:0] req_addr0;
    logic [DW-1:0] req_wdata0, resp_rdata0;
    logic [2:0]    req_funct30;

    data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [2:0]    f3;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, " rdata"}, rd, e.rdata);
            chk({name, " err"}, 32'(er), 32'(e.err));
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        chk({name, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(lat);
        chk({name, " latency"}, 32'(lat), 32'(WC));
        pop_cmp(name, resp_rdata, resp_err);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({name, " resp_valid drop"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic run0(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input string name);
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wd; req_funct30 = f3;
        sb.push_back('{rdata: exp_rd, err: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        chk({name, " resp_valid next cycle"}, 32'(resp_valid0), 32'd1);
        chk({name, " req_ready low"}, 32'(req_ready0), 32'd0);
        pop_cmp(name, resp_rdata0, resp_err0);
        resp_ready0 = 1'b1;
        @(negedge clk);
        resp_ready0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[20];
        int   lat;

        vecs[0]  = '{1'b1, 17'h00100, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 17'h00100, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 17'h00101, 32'hFFFFFF7F, 3'b000, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 17'h00100, 32'h0,        3'b010, 32'hDEAD7FEF, 1'b0};
        vecs[4]  = '{1'b0, 17'h00103, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0};
        vecs[5]  = '{1'b0, 17'h00103, 32'h0,        3'b100, 32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, 17'h00102, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
        vecs[7]  = '{1'b0, 17'h00102, 32'h0,        3'b101, 32'h0000DEAD, 1'b0};
        vecs[8]  = '{1'b0, 17'h00100, 32'h0,        3'b011, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 17'h00100, 32'h00000055, 3'b100, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 17'h00100, 32'h00000000, 3'b110, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 17'h00100, 32'h0,        3'b010, 32'hDEAD7FEF, 1'b0};
        vecs[12] = '{1'b0, 17'h00102, 32'h0,        3'b010, TRAP ? 32'h0 : 32'hDEAD7FEF, TRAP};
        vecs[13] = '{1'b1, 17'h00101, 32'h00001234, 3'b001, 32'h0,        TRAP};
        vecs[14] = '{1'b0, 17'h00100, 32'h0,        3'b010, WORD100,      1'b0};
        vecs[15] = '{1'b1, 17'h1FFFC, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 17'h1FFFE, 32'h0,        3'b001, 32'hFFFFCAFE, 1'b0};
        vecs[17] = '{1'b0, 17'h1FFFC, 32'h0,        3'b000, 32'h0000000D, 1'b0};
        vecs[18] = '{1'b1, 17'h1FFFE, 32'hAAAA8001, 3'b001, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 17'h1FFFC, 32'h0,        3'b010, 32'h8001F00D, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0; resp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_funct30 = '0; resp_ready0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);

        for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Response stall with a competing request that must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h00100; req_funct3 = 3'b010;
        sb.push_back('{rdata: WORD100, err: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(lat);
        chk("stall latency", 32'(lat), 32'(WC));
        pop_cmp("stall", resp_rdata, resp_err);
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d resp_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("stall%0d rdata", i), resp_rdata, WORD100);
            chk($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        run_vec('{1'b0, 17'h00100, 32'h0, 3'b010, WORD100, 1'b0}, "after stall");

        // Reset during WAIT drops the in-flight store; earlier store survives.
        run_vec('{1'b1, 17'h00200, 32'h11111111, 3'b010, 32'h0, 1'b0}, "pre store");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h00200; req_wdata = 32'h12345678; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst resp_err", 32'(resp_err), 32'd0);
        run_vec('{1'b0, 17'h00200, 32'h0, 3'b010, 32'h11111111, 1'b0}, "post reset load");

        // Reset wins over a simultaneous request.
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h00200; req_wdata = 32'h0; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rst prio req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("rst prio resp_valid", 32'(resp_valid), 32'd0);
        run_vec('{1'b0, 17'h00200, 32'h0, 3'b010, 32'h11111111, 1'b0}, "rst prio load");

        // Zero-wait instance.
        run0(1'b1, 17'h00040, 32'hA5A5A5A5, 3'b010, 32'h0,        "w0 sw");
        run0(1'b0, 17'h00040, 32'h0,        3'b010, 32'hA5A5A5A5, "w0 lw");
        run0(1'b0, 17'h00042, 32'h0,        3'b101, 32'h0000A5A5, "w0 lhu");
        chk("w0 idle after", 32'(req_ready0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RV32IM core: the target end of the load/store request interface the CPU issues. Accepts one request at a time over a valid/ready handshake, waits a configurable number of cycles, performs the byte/half/word access on a little-endian byte-addressed array, and returns a single response. Instantiated beside the core's datapath and driven by its load/store unit.

## Interface

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 supported
- ADDR_WIDTH, 17, byte-address width; array holds 2^ADDR_WIDTH bytes
- WAIT_CYCLES, 2, extra cycles between acceptance and response (0 legal)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; synchronous and active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, value in low bits
- req_funct3  input  3  RV32 load/store funct3
- resp_valid  output  1  response present
- resp_ready  input  1  requester takes response
- resp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors
- resp_err  output  1  illegal funct3 or trapped misalignment

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, latch we/addr/wdata/funct3. Go to WAIT with counter=WAIT_CYCLES; if WAIT_CYCLES=0, access and go directly to RESP.
- WAIT: req_ready=0. Counter decrements each cycle. On the edge where the counter reaches 0, perform the access, latch resp_rdata/resp_err, go to RESP.
- RESP: resp_valid=1; resp_rdata/resp_err stable. On resp_ready, return to IDLE. Stays in RESP indefinitely without resp_ready.
- funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. 100/101 with req_we=1, or any other code → resp_err=1, no write, resp_rdata=0.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged. Byte k of a word is at addr+k (little-endian).
- Stores: write only addressed lanes (1, 2 or 4 bytes); other bytes unchanged. resp_rdata=0.
- Address wraps modulo 2^ADDR_WIDTH; no out-of-range error.
- Array contents are not reset.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Request accepted at edge N → resp_valid first high in the cycle after edge N+WAIT_CYCLES; write visible to any later access.
- Throughput: one transaction per WAIT_CYCLES+2 cycles minimum (req_ready low in WAIT and RESP; IDLE re-entered after the resp_ready handshake).
- req_valid in WAIT/RESP ignored; requester holds it.
- Reset mid-operation: return to IDLE next edge; uncommitted store discarded; committed store retained.
- rst takes priority over any handshake in the same cycle.

## Configuration

- DMEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]≠0 → resp_err=1, no write, resp_rdata=0.
- Not defined: low address bits are forced to the access alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds; resp_err only for illegal funct3.

## Structure

- Package dmem_pkg: funct3 enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state enum (IDLE, WAIT, RESP), width constants.
- Sub-module dmem_lane_align: combinational; byte-enable generation and store-lane shifting, plus load-lane extraction and sign/zero extension. FSM, counter and array stay in the top.

## Test plan

- Reset, then SW 0xDEADBEEF @0x100, then LW @0x100 → resp_rdata=0xDEADBEEF, resp_err=0; resp_valid rises WAIT_CYCLES+1 cycles after acceptance.
- After above, SB 0x7F @0x101 then LW @0x100 → 0xDEAD7FEF; LB @0x103 → 0xFFFFFFDE; LBU @0x103 → 0x000000DE; LH @0x102 → 0xFFFFDEAD.
- resp_ready held low 5 cycles in RESP → resp_valid and resp_rdata stable, req_ready=0, new req_valid not accepted.
- funct3=011 load, and LBU with req_we=1 → resp_err=1, resp_rdata=0, memory unchanged.
- LW @0x102 and SH @0x101: with DMEM_MISALIGN_TRAP_EN → resp_err=1, no write; without → access performed at 0x100.
- SW 0x12345678 @0x200, rst asserted in WAIT → IDLE next edge, LW @0x200 returns prior contents; WAIT_CYCLES=0 build: LW response one cycle after acceptance.
